// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: divider state encoding,
// iteration count and the divide-by-zero quotient value.
package mdu_pkg;

  // Divider sequencing states
  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_CALC = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  // One restore step per quotient bit
  localparam int DIV_ITERS = 32;

  // Width of the iteration counter; it wraps to zero on the final step
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

  // Quotient reported when the divisor is zero (MIPS leaves it unpredictable,
  // this pipeline pins it to all ones)
  localparam logic [31:0] DIV_DBZ_QUO = 32'hFFFF_FFFF;

  // True on the iteration whose counter value wraps back to zero
  function automatic logic div_is_last(input logic [DIV_CNT_W-1:0] cnt);
    return cnt == DIV_CNT_W'(DIV_ITERS - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, try subtracting the divisor, keep the difference if it is
// non-negative and report the resulting quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   prem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   prem_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Shift-and-subtract. The partial remainder is always below the divisor,
  // so its top bit is zero and the extra guard bit of the subtraction only
  // ever carries the borrow; keeping the full width avoids dropping bits.
  always_comb begin
    shifted = {prem_i, dvd_msb_i};
    trial   = shifted - {2'b00, dvs_i};
    if (!trial[WIDTH+1]) begin
      prem_o  = trial[WIDTH:0];
      q_bit_o = 1'b1;
    end else begin
      prem_o  = shifted[WIDTH:0];
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div32.sv
// Sequential 32-bit restoring divider for DIV/DIVU. Quotient goes to LO,
// remainder to HI; a fixed 35-cycle latency from the start edge to done.
module div32
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  div_state_e           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 sgn_q, sgn_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH:0]       prem_q, prem_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 bz_q, bz_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 dbz_q, dbz_d;

  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH:0]       step_prem;
  logic                 step_q_bit;

  assign a_neg = sgn_q & a_q[WIDTH-1];
  assign b_neg = sgn_q & b_q[WIDTH-1];

  // The dividend register shifts out its MSB each step and the new quotient
  // bit shifts in at the bottom, so it ends up holding the quotient.
  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .prem_i    (prem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .prem_o    (step_prem),
    .q_bit_o   (step_q_bit)
  );

  // Next-state and datapath update for each phase of the division
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (start && !flush) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = is_signed;
          state_d = DIV_PREP;
        end
      end

      DIV_PREP: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          dvd_d   = a_neg ? -a_q : a_q;
          dvs_d   = b_neg ? -b_q : b_q;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          bz_d    = (b_q == '0);
          prem_d  = '0;
          cnt_d   = '0;
          state_d = DIV_CALC;
        end
      end

      DIV_CALC: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          prem_d = step_prem;
          dvd_d  = {dvd_q[WIDTH-2:0], step_q_bit};
          cnt_d  = cnt_q + 1'b1;
          if (div_is_last(cnt_q)) begin
            state_d = DIV_FIX;
          end
        end
      end

      DIV_FIX: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          if (bz_q) begin
            quo_d = WIDTH'(DIV_DBZ_QUO);
            rem_d = a_q;
            dbz_d = 1'b1;
          end else begin
            quo_d = qneg_q ? -dvd_q : dvd_q;
            rem_d = rneg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
            dbz_d = 1'b0;
          end
          state_d = DIV_DONE;
        end
      end

      DIV_DONE: begin
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any division in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q == DIV_PREP) || (state_q == DIV_CALC) || (state_q == DIV_FIX);
  assign done = (state_q == DIV_DONE);
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;

endmodule
